// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and widths for the fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
  localparam int PC_W = 12;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that clears on clr and saturates at all-ones
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : (en && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, run/halt control, bound fault and retired-cycle counter
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int PROG_LEN = 4096,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [D-1:0]  next_pc,
  input  logic          stall,
  input  logic          halt,
  output logic [D-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic          fault,
  output logic [CW-1:0] cycle_count
);
  fetch_state_t state;
  logic go, bad;
  assign go  = start && state != RUN;
  // one extra bit so PROG_LEN = 2^D never flags a fault
  assign bad = {1'b0, next_pc} >= (D+1)'(PROG_LEN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else if (go) begin
      state   <= RUN;
      pc      <= '0;
      running <= 1'b1;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else if (state == RUN) begin
      if (halt || (bad && !stall)) begin
        state   <= HALTED;
        running <= 1'b0;
        done    <= 1'b1;
        fault   <= !halt;
      end else if (!stall) pc <= next_pc;
    end
  sat_counter #(.CW(CW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (state == RUN),
    .count(cycle_count)
  );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench with a behavioural model of the fetch controller
module tb_pc_fetch_ctrl;
  localparam int D = 12, PL = 16, CW = 5, SAT = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, start = 0, stall = 0, halt = 0;
  logic [D-1:0] next_pc = '0;
  logic [D-1:0] pc;
  logic running, done, fault;
  logic [CW-1:0] cycle_count;
  typedef struct packed {
    logic [D-1:0]  pc;
    logic          running;
    logic          done;
    logic          fault;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int ms = 0, mpc = 0, mcnt = 0;
  bit mf = 0;

  pc_fetch_ctrl #(.D(D), .PROG_LEN(PL), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .next_pc(next_pc), .stall(stall),
    .halt(halt), .pc(pc), .running(running), .done(done), .fault(fault),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t snap();
    exp_t e;
    e.pc = mpc[D-1:0];
    e.running = (ms == 1);
    e.done = (ms == 2);
    e.fault = mf;
    e.cnt = mcnt[CW-1:0];
    return e;
  endfunction

  // ms: 0 idle, 1 running, 2 halted
  task automatic model(input bit s, input bit st, input bit h, input int n);
    if (ms != 1) begin
      if (s) begin ms = 1; mpc = 0; mcnt = 0; mf = 0; end
    end else begin
      mcnt = (mcnt >= SAT) ? SAT : mcnt + 1;
      if (h) ms = 2;
      else if (!st && n >= PL) begin ms = 2; mf = 1; end
      else if (!st) mpc = n % (1 << D);
    end
  endtask

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got pc=%0d run=%0b done=%0b fault=%0b cnt=%0d, want pc=%0d run=%0b done=%0b fault=%0b cnt=%0d",
               nm, $time, a.pc, a.running, a.done, a.fault, a.cnt, e.pc, e.running, e.done, e.fault, e.cnt);
    end
  endtask

  function automatic exp_t act();
    exp_t a;
    a.pc = pc; a.running = running; a.done = done; a.fault = fault; a.cnt = cycle_count;
    return a;
  endfunction

  task automatic cyc(input bit s, input bit st, input bit h, input int n);
    @(negedge clk);
    start = s; stall = st; halt = h; next_pc = n[D-1:0];
    model(s, st, h, n);
    q.push_back(snap());
  endtask

  task automatic areset();
    @(negedge clk);
    start = 0; stall = 0; halt = 0;
    #2 rst_n = 0;
    #1 ms = 0; mpc = 0; mcnt = 0; mf = 0;
    chk("async_reset", act(), snap());
    #1 rst_n = 1;
    q.push_back(snap());
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) chk("cycle", act(), q.pop_front());
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", act(), snap());
    rst_n = 1;
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, mpc + 1);
    cyc(0, 0, 0, 3);
    cyc(0, 0, 1, mpc + 1);
    repeat (2) cyc(0, 0, 0, mpc + 1);
    cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, mpc + 1);
    repeat (3) cyc(0, 1, 0, mpc + 1);
    cyc(0, 0, 0, mpc + 1);
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, mpc + 1);
    cyc(0, 1, 1, mpc + 1);
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, mpc + 1);
    cyc(0, 1, 0, 'h014);
    cyc(0, 0, 0, 'h014);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 7);
    cyc(0, 0, 1, 'hfff);
    cyc(1, 0, 0, 0);
    repeat (40) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 'hfff);
    cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, mpc + 1);
    areset();
    for (int i = 0; i < 3000; i++) begin
      if (ms == 1 && $urandom_range(99) < 1) areset();
      else begin
        int n;
        n = ($urandom_range(99) < 2) ? int'($urandom_range(4095, 16))
          : ($urandom_range(99) < 20) ? int'($urandom_range(15)) : mpc + 1;
        cyc($urandom_range(99) < 8, $urandom_range(99) < 15, $urandom_range(99) < 1, n);
      end
    end
    @(negedge clk);
    start = 0; stall = 0; halt = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
